// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Holds the program counter, presents |
// |               it to a combinational instruction memory and registers the   |
// |               returned word into the IF/ID pipeline slot. Supports stall,  |
// |               branch redirect and slot flush.                              |
// | Option      : FETCH_BOUNDS_CHECK_EN - when defined, fetch stops in a HALT  |
// |               state once the PC runs past the end of the memory.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   MEM_SIZE          instruction memory size in bytes (power of two, > 4)   |
// |   RESET_PC          first fetch address after reset (word-aligned)         |
// | Ports                                                                      |
// |   clk               clock, rising edge                                     |
// |   reset             asynchronous reset, active low                         |
// |   stall             hold the PC and the IF/ID slot                         |
// |   redirect          taken branch, load PC from redirect_pc                 |
// |   redirect_pc[63:0] branch target byte address                             |
// |   flush             squash the IF/ID slot                                  |
// |   address[63:0]     fetch address to memory (equals the PC)                |
// |   instruction[31:0] combinational read data for address                    |
// |   ifid_pc[63:0]     PC of the registered instruction                       |
// |   ifid_instruction  registered instruction word                            |
// |   ifid_valid        IF/ID slot holds a real instruction                    |
// |   halted            fetch stopped at the memory bound                      |
// +----------------------------------------------------------------------------+
module fetch_unit #(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        flush,
   output logic [63:0] address,
   input  logic [31:0] instruction,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instruction,
   output logic        ifid_valid,
   output logic        halted
);

   // Catch an illegal memory size at elaboration time.
   if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_mem_size_check
      $error("fetch_unit: MEM_SIZE must be a power of two greater than 4");
   end

`ifdef FETCH_BOUNDS_CHECK_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic [63:0] w_pc_plus4;
   logic [63:0] w_redirect_target;
   logic        w_unused_bits;

   // Natural 64-bit overflow gives the required modulo-2^64 wrap.
   assign w_pc_plus4        = pc_q + 64'd4;
   // Targets are forced word-aligned, so the low two bits are never consumed.
   assign w_redirect_target = {redirect_pc[63:2], 2'b00};
   assign w_unused_bits     = ^redirect_pc[1:0];

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [64:0] c_mem_limit = 65'(MEM_SIZE);
   logic w_at_bound;
   // Evaluated one bit wider so a PC near 2^64 cannot wrap past the check.
   assign w_at_bound = (({1'b0, pc_q} + 65'd3) >= c_mem_limit);
`endif

   // ---------------------------------------------------------------------
   // Next-state and datapath decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;

      case (state_q)
         IDLE: begin
            pc_d         = RESET_PC;
            ifid_valid_d = 1'b0;
            state_d      = RUN;
         end

         RUN: begin
            if (redirect) begin
               // The word currently being fetched is on the wrong path.
               pc_d         = w_redirect_target;
               ifid_valid_d = 1'b0;
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            else if (w_at_bound) begin
               state_d      = HALT;
               ifid_valid_d = 1'b0;
            end
`endif
            else if (flush) begin
               ifid_valid_d = 1'b0;
               if (!stall) begin
                  pc_d = w_pc_plus4;
               end
            end
            else if (!stall) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = instruction;
               ifid_valid_d = 1'b1;
               pc_d         = w_pc_plus4;
            end
         end

`ifdef FETCH_BOUNDS_CHECK_EN
         HALT: begin
            // Only reset leaves HALT; all pipeline controls are ignored.
            ifid_valid_d = 1'b0;
         end
`endif

         default: begin
            state_d      = IDLE;
            ifid_valid_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= 32'd0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign address          = pc_q;
   assign ifid_pc          = ifid_pc_q;
   assign ifid_instruction = ifid_instr_q;
   assign ifid_valid       = ifid_valid_q;

`ifdef FETCH_BOUNDS_CHECK_EN
   assign halted = (state_q == HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024: instruction memory size in bytes, a power of two greater than 4.
REQ-002 SHALL have parameter RESET_PC, default 64'h0: first fetch address after reset, word-aligned.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port stall, input, 1: hold the PC and the IF/ID outputs.
REQ-006 SHALL have port redirect, input, 1: taken branch; load the PC from redirect_pc.
REQ-007 SHALL have port redirect_pc, input, 64: branch target byte address.
REQ-008 SHALL have port flush, input, 1: squash the IF/ID slot.
REQ-009 SHALL have port address, output, 64: byte address to the instruction memory, equal to the PC.
REQ-010 SHALL have port instruction, input, 32: combinational read data returned for address.
REQ-011 SHALL have port ifid_pc, output, 64: PC of the registered instruction.
REQ-012 SHALL have port ifid_instruction, output, 32: registered instruction word.
REQ-013 SHALL have port ifid_valid, output, 1: IF/ID slot holds a real instruction.
REQ-014 SHALL have port halted, output, 1: fetch stopped at a memory bound.

Function
REQ-015 SHALL implement states IDLE, RUN and HALT; reset enters IDLE, and IDLE moves to RUN on the first rising edge after reset is released.
REQ-016 SHALL drive address combinationally from the PC register, with zero-cycle latency to instruction.
REQ-017 In IDLE, SHALL hold the PC at RESET_PC and SHALL hold ifid_valid at 0.
REQ-018 In RUN with no stall, redirect or flush, each edge SHALL perform: ifid_pc <= PC, ifid_instruction <= instruction, ifid_valid <= 1, PC <= PC+4.
REQ-019 PC+4 SHALL wrap modulo 2^64.
REQ-020 redirect SHALL take priority over stall: PC <= {redirect_pc[63:2],2'b00} and ifid_valid <= 0, because the in-flight fetch is the wrong path.
REQ-021 flush without redirect SHALL set ifid_valid <= 0; the PC advances unless stall is also 1, in which case the PC holds.
REQ-022 stall alone SHALL hold the PC, ifid_pc, ifid_instruction and ifid_valid unchanged.
REQ-023 While ifid_valid is 0, ifid_pc and ifid_instruction SHALL be don't-care; a bench SHALL NOT check them.
REQ-024 halted SHALL be 1 only in HALT.
REQ-025 In HALT, SHALL freeze the PC, force ifid_valid to 0, and ignore stall, redirect and flush; only reset exits HALT.

Reset
REQ-026 Asserting reset SHALL immediately set: PC = RESET_PC, ifid_pc = 0, ifid_instruction = 0, ifid_valid = 0, halted = 0, state = IDLE, with no clock required.
REQ-027 Reset asserted mid-run SHALL discard any pending redirect; the first valid output after release SHALL come from RESET_PC.

Configuration
REQ-028 With macro FETCH_BOUNDS_CHECK_EN defined, in RUN with no redirect, when PC+3 >= MEM_SIZE the next edge SHALL enter HALT instead of performing the REQ-018 update.
REQ-029 With FETCH_BOUNDS_CHECK_EN defined, a redirect to an out-of-bounds target SHALL be taken first; HALT SHALL follow on the next edge.
REQ-030 Without FETCH_BOUNDS_CHECK_EN, the HALT state SHALL be absent, halted SHALL be tied to 0, and the PC SHALL advance without bound checks.

Verification
REQ-031 Sequential fetch: reset 0->1, memory word k = k, no stall -> ifid_valid rises on the 2nd edge; ifid_pc = 0,4,8,… with ifid_instruction = 0,1,2,… on consecutive cycles.
REQ-032 Branch: redirect=1 with redirect_pc=0x40 while PC=0x10 -> next cycle ifid_valid=0; the following cycle ifid_pc=0x40 and ifid_valid=1; redirect_pc=0x43 -> PC=0x40.
REQ-033 Stall/flush: stall=1 for 3 cycles at PC=0x20 -> outputs frozen, address stays 0x20; stall=1 with flush=1 -> ifid_valid=0 and PC stays 0x20.
REQ-034 Bounds with FETCH_BOUNDS_CHECK_EN, MEM_SIZE=1024: the last valid output is ifid_pc=0x3FC; then halted=1, ifid_valid=0, and address is held at 0x400.
REQ-035 Bounds without FETCH_BOUNDS_CHECK_EN: the PC passes 0x400 and halted stays 0; redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> after that fetch, PC wraps to 0.
REQ-036 Reset mid-operation: assert reset at PC=0x80 between clock edges -> all outputs reach their reset values immediately, and after release the fetch restarts at RESET_PC.
